rfg_axis_io_arbiter: RTL and testbench

Frame-aware AXI-Stream arbiter between N byte-oriented I/O interfaces (UART, FTDI, SW FIFO) and the single RFG protocol slave port. Grants one source for a complete protocol frame, tagging forwarded bytes with tid = source index. Routes protocol readback bytes back to the originating interface by tdest.

---
 rtl/rfg_axis_pkg.sv | 27 ++
 rtl/rfg_rr_arbiter.sv | 32 +++
 rtl/rfg_axis_io_arbiter.sv | 177 +++++++++++++++++
 tb/tb_rfg_axis_io_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rfg_axis_pkg.sv
// Shared types and constants for the RFG AXI-Stream I/O arbiter.
package rfg_axis_pkg;

    localparam int unsigned HEADER_WRITE_BIT = 0;
    localparam int unsigned HEADER_READ_BIT  = 1;

    typedef struct packed {
        logic [3:0] vchannel;
        logic       rsvd;
        logic       address_increment;
        logic       read;
        logic       write;
    } header_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_ADDR,
        ST_LEN_A,
        ST_LEN_B,
        ST_PAYLOAD
    } arb_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rfg_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr.
module rfg_rr_arbiter
    import rfg_axis_pkg::*;
#(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned PTR_W   = idx_width(N_PORTS)
) (
    input  logic [N_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [N_PORTS-1:0] o_grant_oh,
    output logic [PTR_W-1:0]   o_grant_idx,
    output logic               o_valid
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_valid     = 1'b0;
        w_idx       = '0;
        for (int unsigned off = 0; off < N_PORTS; off++) begin
            w_idx = PTR_W'((32'(i_ptr) + off) % N_PORTS);
            if (!o_valid && i_req[w_idx]) begin
                o_valid            = 1'b1;
                o_grant_idx        = w_idx;
                o_grant_oh[w_idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rfg_axis_io_arbiter.sv
// Frame-aware AXI-Stream arbiter from N byte interfaces to the RFG protocol slave,
// with tdest-routed readback. Optional mid-frame timeout: `define RFG_ARB_TIMEOUT_EN.
module rfg_axis_io_arbiter
    import rfg_axis_pkg::*;
#(
    parameter int unsigned N_PORTS        = 2,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [N_PORTS*8-1:0]    s_axis_tdata,
    input  logic [N_PORTS-1:0]      s_axis_tvalid,
    output logic [N_PORTS-1:0]      s_axis_tready,
    output logic [7:0]              m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [ID_WIDTH-1:0]     m_axis_tid,
    input  logic [7:0]              s_resp_tdata,
    input  logic                    s_resp_tvalid,
    output logic                    s_resp_tready,
    input  logic                    s_resp_tlast,
    input  logic [ID_WIDTH-1:0]     s_resp_tdest,
    output logic [N_PORTS*8-1:0]    m_resp_tdata,
    output logic [N_PORTS-1:0]      m_resp_tvalid,
    output logic [N_PORTS-1:0]      m_resp_tlast,
    input  logic [N_PORTS-1:0]      m_resp_tready,
    output logic                    frame_error
);

    localparam int unsigned PTR_W = idx_width(N_PORTS);

    arb_state_t          r_state, w_state_nxt;
    logic [PTR_W-1:0]    r_grant, r_rr_ptr;
    logic                r_out_valid;
    logic [7:0]          r_out_data;
    logic [ID_WIDTH-1:0] r_out_tid;
    logic [7:0]          r_len_lo;
    logic [15:0]         r_cnt;
    logic                r_hdr_write;

    logic [N_PORTS-1:0]  w_arb_oh, w_gnt_oh;
    logic [PTR_W-1:0]    w_arb_idx, w_gnt, w_ptr_nxt;
    logic                w_arb_valid, w_slot_free, w_req_valid, w_accept, w_abort;
    logic [7:0]          w_byte;

    rfg_rr_arbiter #(
        .N_PORTS (N_PORTS),
        .PTR_W   (PTR_W)
    ) u_rr (
        .i_req       (s_axis_tvalid),
        .i_ptr       (r_rr_ptr),
        .o_grant_oh  (w_arb_oh),
        .o_grant_idx (w_arb_idx),
        .o_valid     (w_arb_valid)
    );

    // In IDLE the fresh round-robin pick is the grant; mid-frame it is frozen.
    assign w_gnt       = (r_state == ST_IDLE) ? w_arb_idx : r_grant;
    assign w_gnt_oh    = (r_state == ST_IDLE) ? w_arb_oh
                                              : ({{(N_PORTS-1){1'b0}}, 1'b1} << r_grant);
    assign w_slot_free = aresetn && (!r_out_valid || m_axis_tready);
    assign w_req_valid = |(s_axis_tvalid & w_gnt_oh);
    assign w_accept    = w_req_valid && w_slot_free;
    assign w_byte      = s_axis_tdata[{w_gnt, 3'b000} +: 8];
    assign w_ptr_nxt   = (w_arb_idx == PTR_W'(N_PORTS - 1)) ? '0 : w_arb_idx + 1'b1;

    assign s_axis_tready = w_slot_free ? w_gnt_oh : '0;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tid    = r_out_tid;

`ifdef RFG_ARB_TIMEOUT_EN
    logic [31:0] r_idle_cnt;
    logic        r_frame_error;

    assign w_abort     = (r_state != ST_IDLE) && !w_accept
                         && (r_idle_cnt >= 32'(TIMEOUT_CYCLES - 1));
    assign frame_error = r_frame_error;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_idle_cnt    <= '0;
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= w_abort;
            if (r_state == ST_IDLE || w_accept || w_abort)
                r_idle_cnt <= '0;
            else
                r_idle_cnt <= r_idle_cnt + 32'd1;
        end
    end
`else
    assign w_abort     = 1'b0;
    assign frame_error = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                ST_IDLE:
                    if (w_byte[HEADER_WRITE_BIT] || w_byte[HEADER_READ_BIT])
                        w_state_nxt = ST_HDR_ADDR;
                ST_HDR_ADDR: w_state_nxt = ST_LEN_A;
                ST_LEN_A:    w_state_nxt = ST_LEN_B;
                ST_LEN_B:
                    w_state_nxt = (r_hdr_write && ({w_byte, r_len_lo} != 16'd0))
                                  ? ST_PAYLOAD : ST_IDLE;
                ST_PAYLOAD:
                    if (r_cnt == 16'd1) w_state_nxt = ST_IDLE;
                default:     w_state_nxt = ST_IDLE;
            endcase
        end
        if (w_abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tid   <= '0;
            r_len_lo    <= '0;
            r_cnt       <= '0;
            r_hdr_write <= 1'b0;
        end else begin
            if (w_slot_free) begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out_data <= w_byte;
                    r_out_tid  <= ID_WIDTH'(w_gnt);
                end
            end
            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        r_grant     <= w_arb_idx;
                        r_rr_ptr    <= w_ptr_nxt;
                        r_hdr_write <= w_byte[HEADER_WRITE_BIT];
                    end
                    ST_LEN_A:   r_len_lo <= w_byte;
                    ST_LEN_B:   r_cnt    <= {w_byte, r_len_lo};
                    ST_PAYLOAD: r_cnt    <= r_cnt - 16'd1;
                    default: ;
                endcase
            end
        end
    end

    // Readback is a pure combinational demux; out-of-range tdest is swallowed.
    logic [PTR_W-1:0] w_sel;
    logic             w_resp_in_range;

    assign w_sel           = s_resp_tdest[PTR_W-1:0];
    assign w_resp_in_range = (s_resp_tdest < ID_WIDTH'(N_PORTS));

    always_comb begin
        m_resp_tvalid = '0;
        m_resp_tlast  = '0;
        m_resp_tdata  = '0;
        s_resp_tready = 1'b1;
        if (w_resp_in_range) begin
            m_resp_tvalid[w_sel]              = s_resp_tvalid;
            m_resp_tlast[w_sel]               = s_resp_tlast;
            m_resp_tdata[{w_sel, 3'b000} +: 8] = s_resp_tdata;
            s_resp_tready                     = m_resp_tready[w_sel];
        end
    end

endmodule

// File: tb/tb_rfg_axis_io_arbiter.sv
// Directed scoreboard bench for rfg_axis_io_arbiter (N_PORTS=2).
module tb_rfg_axis_io_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [15:0] s_axis_tdata;
    logic [1:0]  s_axis_tvalid;
    logic [1:0]  s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  m_axis_tid;
    logic [7:0]  s_resp_tdata;
    logic        s_resp_tvalid;
    logic        s_resp_tready;
    logic        s_resp_tlast;
    logic [7:0]  s_resp_tdest;
    logic [15:0] m_resp_tdata;
    logic [1:0]  m_resp_tvalid;
    logic [1:0]  m_resp_tlast;
    logic [1:0]  m_resp_tready;
    logic        frame_error;

    always #5 aclk = ~aclk;

    rfg_axis_io_arbiter #(
        .N_PORTS        (2),
        .ID_WIDTH       (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tid    (m_axis_tid),
        .s_resp_tdata  (s_resp_tdata),
        .s_resp_tvalid (s_resp_tvalid),
        .s_resp_tready (s_resp_tready),
        .s_resp_tlast  (s_resp_tlast),
        .s_resp_tdest  (s_resp_tdest),
        .m_resp_tdata  (m_resp_tdata),
        .m_resp_tvalid (m_resp_tvalid),
        .m_resp_tlast  (m_resp_tlast),
        .m_resp_tready (m_resp_tready),
        .frame_error   (frame_error)
    );

    int total = 0;
    int bad   = 0;
    int err_pulses = 0;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [15:0] expq[$];
    logic        rdy_pat[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = '0;
    logic [7:0]  prev_tid   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        s_axis_tvalid[0]  = (q0.size() > 0);
        s_axis_tdata[7:0] = (q0.size() > 0) ? q0[0] : 8'h00;
        s_axis_tvalid[1]  = (q1.size() > 0);
        s_axis_tdata[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
    endtask

    task automatic push_frame(input int p, input int n, input logic [63:0] bytes);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = bytes[8*(n-1-i) +: 8];
            if (p == 0) q0.push_back(b);
            else        q1.push_back(b);
            expq.push_back({p[7:0], b});
        end
        drive_src();
    endtask

    // Called at posedge+1: samples mid-cycle, then advances one clock.
    task automatic cycle();
        logic        hs0, hs1;
        logic [15:0] e;
        #4;
        hs0 = s_axis_tvalid[0] && s_axis_tready[0];
        hs1 = s_axis_tvalid[1] && s_axis_tready[1];
        if (frame_error === 1'b1) err_pulses++;
        check("tready_onehot0", 32'($onehot0(s_axis_tready)), 32'd1);
        if (prev_stall) begin
            check("stall_valid", 32'(m_axis_tvalid), 32'd1);
            check("stall_data", 32'(m_axis_tdata), 32'(prev_data));
            check("stall_tid", 32'(m_axis_tid), 32'(prev_tid));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
            check("out_data", 32'(m_axis_tdata), 32'(e[7:0]));
            check("out_tid", 32'(m_axis_tid), 32'(e[15:8]));
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_tid   = m_axis_tid;
        @(posedge aclk);
        #1;
        if (hs0) void'(q0.pop_front());
        if (hs1) void'(q1.pop_front());
        drive_src();
        m_axis_tready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || expq.size() > 0 || m_axis_tvalid) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_completed"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn       = 1'b0;
        s_axis_tvalid = 2'b11;
        s_axis_tdata  = 16'h0101;
        m_axis_tready = 1'b1;
        s_resp_tdata  = '0;
        s_resp_tvalid = 1'b0;
        s_resp_tlast  = 1'b0;
        s_resp_tdest  = '0;
        m_resp_tready = '0;
        #3;
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_m_tid", 32'(m_axis_tid), 32'd0);
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
        s_axis_tvalid = 2'b00;
        @(posedge aclk);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        drive_src();

        // Write frame from port 1, three payload bytes.
        push_frame(1, 7, 64'h01_10_03_00_AA_BB_CC);
        drain("t1_write_p1", 60);

        // Simultaneous read frames; pointer now favours port 0.
        push_frame(0, 4, 64'h02_20_04_00);
        push_frame(1, 4, 64'h02_20_04_00);
        drain("t2_two_reads", 60);

        // Write frame under output backpressure.
        for (int i = 0; i < 4; i++) begin
            rdy_pat.push_back(1'b1);
            rdy_pat.push_back(1'b0);
            rdy_pat.push_back(1'b0);
            rdy_pat.push_back(1'b1);
        end
        push_frame(0, 6, 64'h01_30_02_00_D1_D2);
        drain("t3_backpressure", 80);

        // Header-only frame, then zero-length write, then a port 0 header proves release.
        push_frame(1, 1, 64'h00);
        push_frame(1, 4, 64'h01_05_00_00);
        drain("t4_len0", 60);
        push_frame(0, 1, 64'h80);
        drain("t4_release", 20);

        // Readback routing.
        s_resp_tdest  = 8'd1;
        s_resp_tdata  = 8'h11;
        s_resp_tlast  = 1'b0;
        s_resp_tvalid = 1'b1;
        m_resp_tready = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("resp_valid_held", 32'(m_resp_tvalid), 32'h2);
            check("resp_data_held", 32'(m_resp_tdata[15:8]), 32'h11);
            check("resp_ready_stalled", 32'(s_resp_tready), 32'd0);
            cycle();
        end
        m_resp_tready = 2'b10;
        #1;
        check("resp_ready_go", 32'(s_resp_tready), 32'd1);
        check("resp_last_first", 32'(m_resp_tlast), 32'd0);
        cycle();
        s_resp_tdata = 8'h22;
        s_resp_tlast = 1'b1;
        #1;
        check("resp_valid_second", 32'(m_resp_tvalid), 32'h2);
        check("resp_data_second", 32'(m_resp_tdata[15:8]), 32'h22);
        check("resp_last_second", 32'(m_resp_tlast), 32'h2);
        cycle();
        s_resp_tdest  = 8'd5;
        s_resp_tdata  = 8'h33;
        m_resp_tready = 2'b00;
        #1;
        check("resp_oor_valid", 32'(m_resp_tvalid), 32'd0);
        check("resp_oor_ready", 32'(s_resp_tready), 32'd1);
        cycle();
        s_resp_tvalid = 1'b0;
        s_resp_tlast  = 1'b0;

`ifdef RFG_ARB_TIMEOUT_EN
        // Port 0 stalls after two bytes; port 1 waits behind it until the abort.
        err_pulses = 0;
        push_frame(0, 2, 64'h01_40);
        cycle();
        cycle();
        cycle();
        push_frame(1, 1, 64'h00);
        drain("t6_timeout", 80);
        check("timeout_pulses", 32'(err_pulses), 32'd1);
`else
        check("no_frame_error", 32'(err_pulses), 32'd0);
`endif

        // Asynchronous reset in the middle of a payload.
        push_frame(0, 8, 64'h01_50_04_00_E1_E2_E3_E4);
        for (int i = 0; i < 6; i++) cycle();
        check("pre_rst_busy", 32'(m_axis_tvalid), 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("midrst_m_tid", 32'(m_axis_tid), 32'd0);
        check("midrst_s_tready", 32'(s_axis_tready), 32'd0);
        check("midrst_frame_error", 32'(frame_error), 32'd0);
        q0.delete();
        q1.delete();
        expq.delete();
        prev_stall = 1'b0;
        drive_src();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        push_frame(1, 1, 64'h00);
        drain("t7_after_reset", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
